// File: rtl/ghost_control.sv
// rtl/ghost_control.sv - per-ghost move sequencer: release delay, chase/scatter, capture
// Optional frightened mode is compiled in when GHOST_FRIGHT_EN is defined.
module ghost_control #(
    parameter int WIDTH         = 96,
    parameter int HEIGHT        = 72,
    parameter int RELEASE_TICKS = 16,
    parameter int CHASE_TICKS   = 200,
    parameter int SCATTER_TICKS = 70,
    parameter int SCATTER_X     = 1,
    parameter int SCATTER_Y     = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       game_start,
    input  logic       tick,
    input  logic       wall_up,
    input  logic       wall_down,
    input  logic       wall_left,
    input  logic       wall_right,
    input  logic [9:0] xGhost,
    input  logic [8:0] yGhost,
    input  logic [9:0] xPac,
    input  logic [8:0] yPac,
`ifdef GHOST_FRIGHT_EN
    input  logic       power,
    output logic       frightened,
`endif
    output logic       m_up,
    output logic       m_down,
    output logic       m_right,
    output logic       m_left,
    output logic       e_start,
    output logic       pac_caught,
    output logic [1:0] mode
);

    localparam int PMAX = (CHASE_TICKS > SCATTER_TICKS) ? CHASE_TICKS : SCATTER_TICKS;
    localparam int RW   = $clog2(RELEASE_TICKS + 1);
    localparam int PW   = $clog2(PMAX + 1);
    // Scatter corner is held inside the board so a bad parameter cannot aim off-map.
    localparam logic [9:0] SX = 10'((SCATTER_X > WIDTH) ? WIDTH : SCATTER_X);
    localparam logic [8:0] SY = 9'((SCATTER_Y > HEIGHT) ? HEIGHT : SCATTER_Y);

    // Direction codes double as the fallback order; reverse is a flip of bit 1.
    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_LEFT  = 2'd1;
    localparam logic [1:0] D_DOWN  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOUSE,
        S_CHASE,
        S_SCATTER
`ifdef GHOST_FRIGHT_EN
        , S_FRIGHT
`endif
    } state_t;

    state_t          state, state_n;
    logic [RW-1:0]   rel_cnt, rel_n;
    logic [PW-1:0]   phase_cnt, phase_n;
    logic [1:0]      cur_dir, dir_n;
    logic [3:0]      move_q, move_n;
    logic            e_start_n, caught_n;

    logic [3:0]      walls;
    logic [1:0]      rev;
    logic [9:0]      tx;
    logic [8:0]      ty;
    logic [10:0]     dx, dy, adx, ady;
    logic            x_pri;
    logic [1:0]      xdir, ydir;
    logic [1:0]      cand [6];
    logic            cand_ok [6];
    logic            move_ok;
    logic [1:0]      move_dir;
    logic            catch_hit;

`ifdef GHOST_FRIGHT_EN
    logic [7:0]      lfsr, lfsr_n;
    logic [6:0]      fright_cnt, fright_n;
    state_t          resume, resume_n;
`endif

    assign walls     = {wall_right, wall_down, wall_left, wall_up};
    assign rev       = cur_dir ^ 2'b10;
    assign catch_hit = (xGhost == xPac) && (yGhost == yPac);

    always_comb begin
        tx    = (state == S_CHASE) ? xPac : SX;
        ty    = (state == S_CHASE) ? yPac : SY;
        dx    = {1'b0, tx} - {1'b0, xGhost};
        dy    = {2'b00, ty} - {2'b00, yGhost};
        adx   = dx[10] ? (11'd0 - dx) : dx;
        ady   = dy[10] ? (11'd0 - dy) : dy;
        x_pri = (adx >= ady);
        xdir  = dx[10] ? D_LEFT : D_RIGHT;
        ydir  = dy[10] ? D_UP : D_DOWN;

        cand[0]    = x_pri ? xdir : ydir;
        cand_ok[0] = x_pri ? (dx != '0) : (dy != '0);
        cand[1]    = x_pri ? ydir : xdir;
        cand_ok[1] = x_pri ? (dy != '0) : (dx != '0);
        for (int i = 0; i < 4; i++) begin
            cand[i+2]    = 2'(i);
            cand_ok[i+2] = 1'b1;
        end
`ifdef GHOST_FRIGHT_EN
        if (state == S_FRIGHT) begin
            for (int i = 0; i < 4; i++) begin
                cand[i]    = lfsr[1:0] + 2'(i);
                cand_ok[i] = 1'b1;
            end
            cand_ok[4] = 1'b0;
            cand_ok[5] = 1'b0;
        end
`endif
        move_ok  = 1'b0;
        move_dir = cur_dir;
        for (int i = 0; i < 6; i++) begin
            if (!move_ok && cand_ok[i] && !walls[cand[i]] && (cand[i] != rev)) begin
                move_ok  = 1'b1;
                move_dir = cand[i];
            end
        end
        if (!move_ok && !walls[rev]) begin
            move_ok  = 1'b1;
            move_dir = rev;
        end
    end

    always_comb begin
        state_n   = state;
        rel_n     = rel_cnt;
        phase_n   = phase_cnt;
        dir_n     = cur_dir;
        move_n    = 4'b0000;
        e_start_n = 1'b0;
        caught_n  = 1'b0;
`ifdef GHOST_FRIGHT_EN
        lfsr_n    = tick ? {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]} : lfsr;
        fright_n  = fright_cnt;
        resume_n  = resume;
`endif
        if (game_start) begin
            e_start_n = 1'b1;
            state_n   = S_HOUSE;
            rel_n     = RW'(RELEASE_TICKS);
            dir_n     = D_LEFT;
        end else begin
            case (state)
                S_HOUSE: begin
                    if (tick) begin
                        if (rel_cnt <= RW'(1)) begin
                            state_n = S_SCATTER;
                            phase_n = PW'(SCATTER_TICKS);
                        end else begin
                            rel_n = rel_cnt - RW'(1);
                        end
                    end
                end
                S_CHASE, S_SCATTER: begin
                    if (catch_hit) begin
                        caught_n  = 1'b1;
                        e_start_n = 1'b1;
                        state_n   = S_HOUSE;
                        rel_n     = RW'(RELEASE_TICKS);
                        dir_n     = D_LEFT;
`ifdef GHOST_FRIGHT_EN
                    end else if (power) begin
                        state_n  = S_FRIGHT;
                        resume_n = state;
                        fright_n = 7'd64;
`endif
                    end else if (tick) begin
                        if (move_ok) move_n[move_dir] = 1'b1;
                        dir_n = move_dir;
                        if (phase_cnt <= PW'(1)) begin
                            // Phase swap: ghost turns around on the boundary tick.
                            dir_n   = move_dir ^ 2'b10;
                            state_n = (state == S_SCATTER) ? S_CHASE : S_SCATTER;
                            phase_n = (state == S_SCATTER) ? PW'(CHASE_TICKS) : PW'(SCATTER_TICKS);
                        end else begin
                            phase_n = phase_cnt - PW'(1);
                        end
                    end
                end
`ifdef GHOST_FRIGHT_EN
                S_FRIGHT: begin
                    if (catch_hit) begin
                        e_start_n = 1'b1;
                        state_n   = S_HOUSE;
                        rel_n     = RW'(RELEASE_TICKS);
                        dir_n     = D_LEFT;
                    end else if (tick) begin
                        if (move_ok) move_n[move_dir] = 1'b1;
                        dir_n = move_dir;
                        if (fright_cnt <= 7'd1) state_n = resume;
                        else fright_n = fright_cnt - 7'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            rel_cnt    <= '0;
            phase_cnt  <= '0;
            cur_dir    <= D_LEFT;
            move_q     <= 4'b0000;
            e_start    <= 1'b0;
            pac_caught <= 1'b0;
`ifdef GHOST_FRIGHT_EN
            lfsr       <= 8'hA5;
            fright_cnt <= '0;
            resume     <= S_SCATTER;
`endif
        end else begin
            state      <= state_n;
            rel_cnt    <= rel_n;
            phase_cnt  <= phase_n;
            cur_dir    <= dir_n;
            move_q     <= move_n;
            e_start    <= e_start_n;
            pac_caught <= caught_n;
`ifdef GHOST_FRIGHT_EN
            lfsr       <= lfsr_n;
            fright_cnt <= fright_n;
            resume     <= resume_n;
`endif
        end
    end

    assign m_up    = move_q[D_UP];
    assign m_left  = move_q[D_LEFT];
    assign m_down  = move_q[D_DOWN];
    assign m_right = move_q[D_RIGHT];

    always_comb begin
        case (state)
            S_HOUSE:   mode = 2'd1;
            S_CHASE:   mode = 2'd2;
            S_SCATTER: mode = 2'd3;
`ifdef GHOST_FRIGHT_EN
            S_FRIGHT:  mode = 2'd3;
`endif
            default:   mode = 2'd0;
        endcase
    end

`ifdef GHOST_FRIGHT_EN
    assign frightened = (state == S_FRIGHT);
`endif

endmodule

// File: tb/tb_ghost_control.sv
// tb/tb_ghost_control.sv - directed self-checking bench for ghost_control
module tb_ghost_control;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       game_start = 1'b0;
    logic       tick = 1'b0;
    logic       wall_up = 1'b0, wall_down = 1'b0, wall_left = 1'b0, wall_right = 1'b0;
    logic [9:0] xGhost = 10'd46, xPac = 10'd90;
    logic [8:0] yGhost = 9'd28, yPac = 9'd60;
    logic       m_up, m_down, m_right, m_left, e_start, pac_caught;
    logic [1:0] mode;
`ifdef GHOST_FRIGHT_EN
    logic       power = 1'b0;
    logic       frightened;
`endif

    int checks = 0;
    int fails  = 0;

    localparam logic [3:0] MV_NONE  = 4'b0000;
    localparam logic [3:0] MV_UP    = 4'b1000;
    localparam logic [3:0] MV_DOWN  = 4'b0100;
    localparam logic [3:0] MV_RIGHT = 4'b0010;
    localparam logic [3:0] MV_LEFT  = 4'b0001;

    wire [3:0] moves = {m_up, m_down, m_right, m_left};

    ghost_control dut (
        .clk(clk), .reset_n(reset_n), .game_start(game_start), .tick(tick),
        .wall_up(wall_up), .wall_down(wall_down), .wall_left(wall_left), .wall_right(wall_right),
        .xGhost(xGhost), .yGhost(yGhost), .xPac(xPac), .yPac(yPac),
`ifdef GHOST_FRIGHT_EN
        .power(power), .frightened(frightened),
`endif
        .m_up(m_up), .m_down(m_down), .m_right(m_right), .m_left(m_left),
        .e_start(e_start), .pac_caught(pac_caught), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic set_walls(input logic u, input logic d, input logic l, input logic r);
        wall_up = u; wall_down = d; wall_left = l; wall_right = r;
    endtask

    task automatic set_pos(input int xg, input int yg, input int xp, input int yp);
        xGhost = 10'(xg); yGhost = 9'(yg); xPac = 10'(xp); yPac = 9'(yp);
    endtask

    // Tick asserted for one cycle; returns at the next falling edge with outputs registered.
    task automatic pulse_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
    endtask

    task automatic start_game();
        @(negedge clk) game_start = 1'b1;
        @(negedge clk) game_start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (moves !== MV_NONE) begin fails++; $display("FAIL reset_moves got=%b exp=%b", moves, MV_NONE); end
        checks++; if (e_start !== 1'b0 || pac_caught !== 1'b0) begin fails++; $display("FAIL reset_pulses got=%b%b exp=00", e_start, pac_caught); end
        checks++; if (mode !== 2'd0) begin fails++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        reset_n = 1'b1;
        pulse_tick();
        checks++; if (moves !== MV_NONE || mode !== 2'd0) begin fails++; $display("FAIL idle_tick got=%b/%0d exp=%b/0", moves, mode, MV_NONE); end
    endtask

    task automatic test_house();
        set_walls(0, 0, 0, 0);
        set_pos(46, 28, 90, 60);
        start_game();
        checks++; if (e_start !== 1'b1 || mode !== 2'd1) begin fails++; $display("FAIL start_estart got=%b/%0d exp=1/1", e_start, mode); end
        @(negedge clk);
        checks++; if (e_start !== 1'b0) begin fails++; $display("FAIL start_estart_width got=%b exp=0", e_start); end
        for (int i = 1; i <= 16; i++) begin
            pulse_tick();
            checks++;
            if (moves !== MV_NONE || mode !== ((i == 16) ? 2'd3 : 2'd1)) begin
                fails++;
                $display("FAIL house_tick%0d got=%b/%0d exp=%b/%0d", i, moves, mode, MV_NONE, (i == 16) ? 3 : 1);
            end
        end
    endtask

    task automatic test_scatter_move();
        set_pos(46, 28, 90, 60);
        pulse_tick();
        checks++; if (moves !== MV_LEFT) begin fails++; $display("FAIL scatter_first got=%b exp=%b", moves, MV_LEFT); end
        @(negedge clk);
        checks++; if (moves !== MV_NONE) begin fails++; $display("FAIL scatter_pulse_width got=%b exp=%b", moves, MV_NONE); end
        set_pos(1, 0, 90, 60);
        pulse_tick();
        checks++; if (moves !== MV_DOWN) begin fails++; $display("FAIL scatter_down got=%b exp=%b", moves, MV_DOWN); end
        set_walls(1, 1, 1, 1);
        for (int i = 0; i < 67; i++) pulse_tick();
        checks++; if (moves !== MV_NONE || mode !== 2'd3) begin fails++; $display("FAIL scatter_boxed got=%b/%0d exp=%b/3", moves, mode, MV_NONE); end
        pulse_tick();
        checks++; if (mode !== 2'd2) begin fails++; $display("FAIL scatter_to_chase got=%0d exp=2", mode); end
    endtask

    task automatic test_chase_fallback();
        set_walls(0, 1, 0, 0);
        set_pos(10, 10, 10, 20);
        pulse_tick();
        checks++; if (moves !== MV_UP) begin fails++; $display("FAIL chase_fallback got=%b exp=%b", moves, MV_UP); end
    endtask

    task automatic test_dead_end();
        set_walls(0, 0, 0, 0);
        set_pos(10, 10, 20, 10);
        pulse_tick();
        checks++; if (moves !== MV_RIGHT) begin fails++; $display("FAIL chase_right got=%b exp=%b", moves, MV_RIGHT); end
        set_walls(1, 1, 0, 1);
        pulse_tick();
        checks++; if (moves !== MV_LEFT) begin fails++; $display("FAIL dead_end got=%b exp=%b", moves, MV_LEFT); end
    endtask

    task automatic test_back_to_back();
        set_walls(0, 0, 0, 0);
        set_pos(10, 10, 20, 10);
        @(negedge clk) tick = 1'b1;
        @(negedge clk);
        checks++; if (moves !== MV_UP) begin fails++; $display("FAIL b2b_first got=%b exp=%b", moves, MV_UP); end
        @(negedge clk) tick = 1'b0;
        checks++; if (moves !== MV_RIGHT) begin fails++; $display("FAIL b2b_second got=%b exp=%b", moves, MV_RIGHT); end
    endtask

    task automatic test_reset_mid_chase();
        @(negedge clk) tick = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (moves !== MV_RIGHT) begin fails++; $display("FAIL pre_reset_move got=%b exp=%b", moves, MV_RIGHT); end
        tick = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++; if (moves !== MV_NONE || mode !== 2'd0 || e_start !== 1'b0) begin fails++; $display("FAIL async_reset got=%b/%0d/%b exp=%b/0/0", moves, mode, e_start, MV_NONE); end
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            checks++; if (moves !== MV_NONE || mode !== 2'd0) begin fails++; $display("FAIL post_reset_tick%0d got=%b/%0d exp=%b/0", i, moves, mode, MV_NONE); end
        end
    endtask

    task automatic test_capture();
        set_walls(1, 1, 1, 1);
        set_pos(46, 28, 90, 60);
        start_game();
        checks++; if (e_start !== 1'b1) begin fails++; $display("FAIL restart_estart got=%b exp=1", e_start); end
        for (int i = 0; i < 16; i++) pulse_tick();
        checks++; if (mode !== 2'd3) begin fails++; $display("FAIL capture_setup got=%0d exp=3", mode); end
        set_walls(0, 0, 0, 0);
        @(negedge clk) begin tick = 1'b1; set_pos(30, 30, 30, 30); end
        @(negedge clk) begin tick = 1'b0; set_pos(46, 28, 90, 60); end
        checks++; if (pac_caught !== 1'b1 || e_start !== 1'b1) begin fails++; $display("FAIL capture_pulses got=%b%b exp=11", pac_caught, e_start); end
        checks++; if (moves !== MV_NONE) begin fails++; $display("FAIL capture_no_move got=%b exp=%b", moves, MV_NONE); end
        checks++; if (mode !== 2'd1) begin fails++; $display("FAIL capture_mode got=%0d exp=1", mode); end
        @(negedge clk);
        checks++; if (pac_caught !== 1'b0 || e_start !== 1'b0) begin fails++; $display("FAIL capture_width got=%b%b exp=00", pac_caught, e_start); end
    endtask

    initial begin
        test_reset();
        test_house();
        test_scatter_move();
        test_chase_fallback();
        test_dead_end();
        test_back_to_back();
        test_reset_mid_chase();
        test_capture();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ghost_control.md
Name: ghost_control

Overview:
- Sequencer for one ghost's position datapath.
- On each movement tick it decides one move and drives the datapath's one-hot m_up/m_down/m_right/m_left pulses and its e_start re-home pulse.
- Runs release delay, chase/scatter alternation and capture handling.
- Sits between the game timer, maze wall lookup, Pac-Man position and the ghost datapath; one instance per ghost.

Parameters:
- WIDTH, 96, board width in cells; matches the datapath.
- HEIGHT, 72, board height in cells; matches the datapath.
- RELEASE_TICKS, 16, ticks spent in the house before the first move.
- CHASE_TICKS, 200, ticks per chase phase.
- SCATTER_TICKS, 70, ticks per scatter phase.
- SCATTER_X, 1, scatter target x.
- SCATTER_Y, 1, scatter target y.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- game_start  in  1  one-cycle pulse; starts or restarts the round.
- tick  in  1  one-cycle movement strobe.
- wall_up, wall_down, wall_left, wall_right  in  1 each  high = cell adjacent to the ghost in that direction is blocked.
- xGhost  in  10  ghost x from datapath.
- yGhost  in  9  ghost y from datapath.
- xPac  in  10  Pac-Man x.
- yPac  in  9  Pac-Man y.
- m_up, m_down, m_right, m_left  out  1 each  one-cycle move pulses to the datapath.
- e_start  out  1  one-cycle re-home pulse to the datapath.
- pac_caught  out  1  one-cycle pulse when the ghost lands on Pac-Man.
- mode  out  2  0=IDLE, 1=HOUSE, 2=CHASE, 3=SCATTER.

Behaviour:
- Reset (reset_n low, async): state IDLE; all pulse outputs 0; mode 0; tick/phase counters 0; cur_dir=LEFT.
- IDLE:
  - game_start -> e_start=1 next cycle, then HOUSE with release counter = RELEASE_TICKS.
  - Ticks are ignored.
- HOUSE:
  - Each tick decrements the release counter; no moves.
  - Counter reaching 0 on a tick -> SCATTER with phase counter = SCATTER_TICKS.
- SCATTER/CHASE:
  - Each tick decrements the phase counter.
  - On reaching 0: swap state and load the other phase length. SCATTER->CHASE loads CHASE_TICKS; CHASE->SCATTER loads SCATTER_TICKS.
  - cur_dir is set to its reverse on each swap.
  - Target: CHASE = (xPac, yPac); SCATTER = (SCATTER_X, SCATTER_Y).
- Move decision, made only on tick in SCATTER/CHASE:
  - dx = target_x - xGhost and dy = target_y - yGhost, 11-bit signed.
  - Primary axis = larger |dx| vs |dy|; ties pick x. Primary candidate points toward the target on that axis; skipped if that delta is 0.
  - Secondary candidate points toward the target on the other axis; skipped if 0.
  - Then fixed fallback order: UP, LEFT, DOWN, RIGHT.
  - First candidate that is not walled and not reverse(cur_dir) wins.
  - If none, reverse(cur_dir) if not walled; otherwise no move.
  - The chosen direction updates cur_dir.
  - No tunnel-aware distance: raw coordinates are used, and the datapath performs wrap at 0 / WIDTH+1.
- Latency:
  - tick sampled at edge N; move pulse registered and high for exactly the cycle after edge N.
  - At most one of m_* is high in any cycle.
  - wall_* must be valid for the current position in the tick cycle.
  - Back-to-back ticks are each honoured.
- Capture:
  - Checked every cycle in SCATTER/CHASE when xGhost==xPac and yGhost==yPac.
  - Capture drives pac_caught=1 and e_start=1 together for one cycle.
  - The block then enters HOUSE with release counter = RELEASE_TICKS and cur_dir=LEFT.
  - Capture and tick in the same cycle: capture wins, no move pulse.
- game_start in any state, including mid-phase: e_start pulse and HOUSE reload; game_start overrides capture and tick.
- reset_n deasserted mid-move: the pending pulse is dropped.

Optional Feature:
- Macro: GHOST_FRIGHT_EN.
- Enabled:
  - Adds input `power` (1-cycle pulse) and output `frightened` (1).
  - `power` in SCATTER/CHASE enters FRIGHT for 64 ticks; mode output reads 3 during FRIGHT.
  - FRIGHT decision uses an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5), advanced every tick. LFSR[1:0] picks the starting index into the UP, LEFT, DOWN, RIGHT fallback order; walled and reverse directions are excluded as above.
  - Capture in FRIGHT gives e_start=1, pac_caught=0, then HOUSE.
  - On expiry, FRIGHT returns to the interrupted state with its phase counter frozen meanwhile.
- Disabled: no FRIGHT state, no LFSR, no `power`/`frightened` ports.

Test Plan:
- Reset low mid-CHASE -> all outputs 0, mode=0 immediately; ticks after release produce no pulses until game_start.
- game_start, then 16 ticks -> e_start one cycle after start, no m_* during HOUSE, mode=3 after 16th tick.
- Scatter from (46,28), no walls -> first tick gives m_left (dx=-45 dominates dy=-27); cur_dir=LEFT.
- CHASE at (10,10), Pac (10,20), wall_down=1, cur_dir=UP -> primary DOWN walled and reverse; fallback UP allowed -> m_up.
- Dead end: cur_dir=RIGHT, wall_up/right/down=1 -> reverse m_left emitted.
- Ghost reaches Pac position on same cycle as tick -> pac_caught=1, e_start=1, no m_*, mode=1.
